// File: rtl/fan_pkg.sv
// Shared helpers for the segmented fan-in tree: width math and output reduction.
// Latency: n/a (package only).
// Backpressure: n/a. Macro FAN_SAT_EN selects saturating reduction; otherwise sums wrap.
package fan_pkg;

  // Pipeline depth for an N-lane tree.
  function automatic int fan_log2(input int n);
    return $clog2(n);
  endfunction

  // Internal sum width: a full-width segment of N lanes can never overflow this.
  function automatic int fan_sum_w(input int dw_in, input int n);
    return dw_in + $clog2(n);
  endfunction

  // Reduce a wide signed sum to dw bits; result is sign-extended back to 64 bits.
  function automatic logic signed [63:0] fan_reduce(input logic signed [63:0] v, input int dw);
`ifdef FAN_SAT_EN
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
`else
    return (v <<< (64 - dw)) >>> (64 - dw);
`endif
  endfunction

endpackage

// File: rtl/fan_tree_pipe_if.sv
// Beat-level handshake bundle for fan_tree_pipe: input beat and result beat.
// Latency: n/a (wiring only).
// Backpressure: valid/ready on both sides; master drives inputs, slave is the block.
interface fan_tree_pipe_if #(
  parameter int N      = 32,
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 16
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DW_IN*N-1:0]    in_data;
  logic [N-1:0]          in_seg_end;
  logic                  out_valid;
  logic                  out_ready;
  logic [DW_OUT*N-1:0]   out_data;
  logic [N-1:0]          out_mask;

  modport master (
    output in_valid, in_data, in_seg_end, out_ready,
    input  in_ready, out_valid, out_data, out_mask
  );

  modport slave (
    input  in_valid, in_data, in_seg_end, out_ready,
    output in_ready, out_valid, out_data, out_mask
  );
endinterface

// File: rtl/fan_scan_stage.sv
// One registered level of the segmented scan: lane i adds lane i-D unless a segment start intervenes.
// Latency: 1 cycle.
// Backpressure: holds all state (including bubbles) while en is low.
module fan_scan_stage #(
  parameter int D = 1,
  parameter int N = 32,
  parameter int W = 13
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  in_vld,
  input  logic [N-1:0][W-1:0]   in_dat,
  input  logic [N-1:0]          in_seg,
  input  logic [N-1:0]          in_end,
  output logic                  out_vld,
  output logic [N-1:0][W-1:0]   out_dat,
  output logic [N-1:0]          out_seg,
  output logic [N-1:0]          out_end
);

  logic [N-1:0][W-1:0] nxt_dat;
  logic [N-1:0]        nxt_seg;

  // in_seg[i] means lane i's window already reaches a segment start, so it must stop accumulating.
  always_comb begin
    nxt_dat = in_dat;
    nxt_seg = in_seg;
    for (int i = D; i < N; i++) begin
      if (!in_seg[i]) begin
        nxt_dat[i] = in_dat[i] + in_dat[i-D];
        nxt_seg[i] = in_seg[i-D];
      end
    end
  end

  // Level register; a global enable freezes the whole pipe during a stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_vld <= 1'b0;
      out_dat <= '0;
      out_seg <= '0;
      out_end <= '0;
    end else if (en) begin
      out_vld <= in_vld;
      out_dat <= nxt_dat;
      out_seg <= nxt_seg;
      out_end <= in_end;
    end
  end

endmodule

// File: rtl/fan_tree_pipe.sv
// Segmented sum of N signed lanes: each lane marked as a segment end receives the sum of its segment.
// Latency: LOG2N cycles, one beat per cycle; macro FAN_SAT_EN selects saturating (vs wrapping) outputs.
// Backpressure: out_valid && !out_ready freezes every stage; in_ready is low while frozen or in reset.
module fan_tree_pipe
  import fan_pkg::*;
#(
  parameter int N      = 32,
  parameter int DW_IN  = 8,
  parameter int DW_OUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  fan_tree_pipe_if.slave    bus,
  output logic              busy
);

  localparam int LOG2N = fan_log2(N);
  localparam int W     = fan_sum_w(DW_IN, N);

  logic                stall;
  logic                en;
  logic [N-1:0]        eff_end;
  logic [N-1:0][W-1:0] s0_dat;

  // Index 0 is the accepted input beat; index k is the output of level k-1.
  logic                vld_q [LOG2N+1];
  logic [N-1:0][W-1:0] dat_q [LOG2N+1];
  logic [N-1:0]        seg_q [LOG2N+1];
  logic [N-1:0]        end_q [LOG2N+1];

  assign stall        = bus.out_valid && !bus.out_ready;
  assign en           = !stall;
  assign bus.in_ready = !stall && !rst;

  // The last lane always closes a segment so no partial sum is left behind.
  assign eff_end = bus.in_seg_end | (N'(1) << (N - 1));

  // Sign-extend each lane to the internal width once at the pipe entry.
  always_comb begin
    s0_dat = '0;
    for (int i = 0; i < N; i++) begin
      s0_dat[i] = W'($signed(bus.in_data[i*DW_IN +: DW_IN]));
    end
  end

  assign vld_q[0] = bus.in_valid && bus.in_ready;
  assign dat_q[0] = s0_dat;
  assign seg_q[0] = {eff_end[N-2:0], 1'b1};
  assign end_q[0] = eff_end;

  for (genvar k = 0; k < LOG2N; k++) begin : g_stage
    fan_scan_stage #(
      .D (1 << k),
      .N (N),
      .W (W)
    ) u_stage (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .in_vld  (vld_q[k]),
      .in_dat  (dat_q[k]),
      .in_seg  (seg_q[k]),
      .in_end  (end_q[k]),
      .out_vld (vld_q[k+1]),
      .out_dat (dat_q[k+1]),
      .out_seg (seg_q[k+1]),
      .out_end (end_q[k+1])
    );
  end

  assign bus.out_valid = vld_q[LOG2N];

  // After the last level every window reaches a segment start; the AND only confirms a complete sum.
  assign bus.out_mask = end_q[LOG2N] & seg_q[LOG2N];

  // Reduce segment sums to the output width; non-terminal lanes read as zero.
  always_comb begin
    bus.out_data = '0;
    for (int i = 0; i < N; i++) begin
      if (bus.out_mask[i]) begin
        bus.out_data[i*DW_OUT +: DW_OUT] =
          DW_OUT'(fan_reduce(64'($signed(dat_q[LOG2N][i])), DW_OUT));
      end
    end
  end

  // Busy whenever any level holds a live beat.
  always_comb begin
    busy = 1'b0;
    for (int k = 1; k <= LOG2N; k++) begin
      busy = busy | vld_q[k];
    end
  end

endmodule

// File: tb/tb_fan_tree_pipe.sv
// Directed bench for fan_tree_pipe: vector table on an 8-lane instance plus stall, reset and width cases.
// Latency: checks LOG2N-cycle result timing.
// Backpressure: exercises a 5-cycle out_ready drop mid-stream.
module tb_fan_tree_pipe;

  logic clk = 1'b0;
  logic rst;
  logic busy8;
  logic busy32;
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fan_tree_pipe_if #(.N(8),  .DW_IN(8), .DW_OUT(12)) bus8  ();
  fan_tree_pipe_if #(.N(32), .DW_IN(8), .DW_OUT(10)) bus32 ();

  fan_tree_pipe #(.N(8),  .DW_IN(8), .DW_OUT(12)) dut8  (.clk(clk), .rst(rst), .bus(bus8),  .busy(busy8));
  fan_tree_pipe #(.N(32), .DW_IN(8), .DW_OUT(10)) dut32 (.clk(clk), .rst(rst), .bus(bus32), .busy(busy32));

  typedef struct {
    logic [7:0][7:0]  din;
    logic [7:0]       seg;
    logic [7:0]       mask;
    logic [7:0][11:0] dout;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_vec(input int idx);
    int cyc;
    bit got;
    bus8.in_data    = vecs[idx].din;
    bus8.in_seg_end = vecs[idx].seg;
    bus8.in_valid   = 1'b1;
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      bus8.in_valid = 1'b0;
      if (bus8.out_valid) got = 1;
    end
    chk($sformatf("vec%0d_latency", idx), cyc, 3);
    chk($sformatf("vec%0d_mask", idx), bus8.out_mask, vecs[idx].mask);
    chk($sformatf("vec%0d_data", idx), bus8.out_data, vecs[idx].dout);
  endtask

  task automatic run_wide();
    int cyc;
    bit got;
    logic [9:0] exp31;
`ifdef FAN_SAT_EN
    exp31 = 10'h1FF;
`else
    exp31 = 10'h3E0;
`endif
    bus32.in_data    = {32{8'd127}};
    bus32.in_seg_end = 32'h0;
    bus32.in_valid   = 1'b1;
    cyc = 0;
    got = 0;
    while (!got && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
      bus32.in_valid = 1'b0;
      if (bus32.out_valid) got = 1;
    end
    chk("wide_latency", cyc, 5);
    chk("wide_mask", bus32.out_mask, 32'h8000_0000);
    chk("wide_lane31", bus32.out_data[319:310], exp31);
    chk("wide_lane0", bus32.out_data[9:0], 10'h0);
  endtask

  task automatic stream_test();
    int sent;
    int rcvd;
    int stalls;
    bit prev_stall;
    bit stl;
    bit acc;
    bit drn;
    logic [103:0] prev_out;
    logic [95:0]  expd;
    sent = 0; rcvd = 0; stalls = 0; prev_stall = 0; prev_out = '0;
    for (int cyc = 0; cyc < 60 && rcvd < 6; cyc++) begin
      bus8.out_ready  = !(cyc >= 5 && cyc < 10);
      bus8.in_valid   = (sent < 6);
      bus8.in_data    = {8{8'(sent + 1)}};
      bus8.in_seg_end = 8'h00;
      #1;
      stl = bus8.out_valid && !bus8.out_ready;
      acc = bus8.in_valid && bus8.in_ready;
      drn = bus8.out_valid && bus8.out_ready;
      if (stl) begin
        stalls++;
        chk("stream_in_ready_stall", bus8.in_ready, 1'b0);
        if (prev_stall) chk("stream_hold", {bus8.out_mask, bus8.out_data}, prev_out);
        prev_out = {bus8.out_mask, bus8.out_data};
      end
      prev_stall = stl;
      if (drn) begin
        expd = '0;
        expd[95:84] = 12'(8 * (rcvd + 1));
        chk($sformatf("stream_beat%0d", rcvd), {bus8.out_mask, bus8.out_data}, {8'h80, expd});
        rcvd++;
      end
      if (acc) sent++;
      @(posedge clk); #1;
    end
    bus8.in_valid  = 1'b0;
    bus8.out_ready = 1'b1;
    chk("stream_count", rcvd, 6);
    chk("stream_stall_cycles", stalls, 5);
  endtask

  task automatic reset_test();
    int first;
    int nvalid;
    bus8.out_ready = 1'b1;
    for (int b = 0; b < 3; b++) begin
      bus8.in_data    = {8{8'(10 + b)}};
      bus8.in_seg_end = 8'hFF;
      bus8.in_valid   = 1'b1;
      @(posedge clk); #1;
    end
    bus8.in_valid = 1'b0;
    chk("rst_busy_inflight", busy8, 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_in_ready_low", bus8.in_ready, 1'b0);
    @(posedge clk); #1;
    chk("rst_out_valid", bus8.out_valid, 1'b0);
    chk("rst_busy", busy8, 1'b0);
    chk("rst_out_mask", bus8.out_mask, 8'h00);
    chk("rst_out_data", bus8.out_data, 96'h0);
    rst = 1'b0;
    #1;
    chk("rst_in_ready_release", bus8.in_ready, 1'b1);
    bus8.in_data    = {8{8'd2}};
    bus8.in_seg_end = 8'hFF;
    bus8.in_valid   = 1'b1;
    first = 0;
    nvalid = 0;
    for (int c = 1; c <= 10; c++) begin
      @(posedge clk); #1;
      bus8.in_valid = 1'b0;
      if (bus8.out_valid) begin
        nvalid++;
        if (first == 0) begin
          first = c;
          chk("rst_post_data", bus8.out_data, {8{12'd2}});
        end
      end
    end
    chk("rst_post_latency", first, 3);
    chk("rst_post_count", nvalid, 1);
  endtask

  initial begin
    vecs[0].din = {8{8'd1}};  vecs[0].seg = 8'h88; vecs[0].mask = 8'h88;
    vecs[0].dout = '0; vecs[0].dout[3] = 12'd4; vecs[0].dout[7] = 12'd4;

    vecs[1].din = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vecs[1].seg = 8'h00; vecs[1].mask = 8'h80;
    vecs[1].dout = '0; vecs[1].dout[7] = 12'd36;

    vecs[2].din = {8{8'h80}}; vecs[2].seg = 8'h00; vecs[2].mask = 8'h80;
    vecs[2].dout = '0; vecs[2].dout[7] = 12'hC00;

    vecs[3].din = {8{8'd1}};  vecs[3].seg = 8'hFF; vecs[3].mask = 8'hFF;
    vecs[3].dout = {8{12'd1}};

    vecs[4].din = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vecs[4].seg = 8'h05; vecs[4].mask = 8'h85;
    vecs[4].dout = '0; vecs[4].dout[0] = 12'd1; vecs[4].dout[2] = 12'd5; vecs[4].dout[7] = 12'd30;

    vecs[5].din = {8'd0, 8'd0, 8'd0, 8'd5, 8'h80, 8'hFF, 8'h7F, 8'h7F};
    vecs[5].seg = 8'h0A; vecs[5].mask = 8'h8A;
    vecs[5].dout = '0; vecs[5].dout[1] = 12'h0FE; vecs[5].dout[3] = 12'hF7F; vecs[5].dout[7] = 12'd5;

    vecs[6].din = {8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    vecs[6].seg = 8'h40; vecs[6].mask = 8'hC0;
    vecs[6].dout = '0; vecs[6].dout[6] = 12'd28; vecs[6].dout[7] = 12'd8;

    rst = 1'b1;
    bus8.in_valid   = 1'b0; bus8.in_data  = '0; bus8.in_seg_end  = '0; bus8.out_ready  = 1'b1;
    bus32.in_valid  = 1'b0; bus32.in_data = '0; bus32.in_seg_end = '0; bus32.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_out_valid", bus8.out_valid, 1'b0);
    chk("reset_busy", busy8, 1'b0);
    chk("reset_out_mask", bus8.out_mask, 8'h00);
    chk("reset_out_data", bus8.out_data, 96'h0);
    chk("reset_in_ready", bus8.in_ready, 1'b0);
    chk("reset_wide_valid", bus32.out_valid, 1'b0);
    rst = 1'b0;
    #1;
    chk("release_in_ready", bus8.in_ready, 1'b1);
    @(posedge clk); #1;

    for (int i = 0; i < 7; i++) run_vec(i);
    run_wide();
    stream_test();
    reset_test();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
